// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode, buffered command and issue FSM state.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef logic [2:0] alu_sel_t;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      alu_sel_t         sel;
      logic             use_acc;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } alu_issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a show-ahead head; full/empty derive from the occupancy count.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  alu_cmd_t      wr_data,
   input  logic          pop,
   output alu_cmd_t      rd_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   alu_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a cleared count makes every entry unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue/capture stage around the combinational 32-bit ALU.
// Optional accumulator chaining is built when ALU_ISSUE_ACC_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing in flight; waiting for the FIFO to hold a command
// ST_EXEC | alu_* driven this cycle; alu_out captured at the next edge
// ST_DONE | result held on res_*; waiting for res_ready
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ALU_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [W-1:0]           cmd_a,
   input  logic [W-1:0]           cmd_b,
   input  logic [2:0]             cmd_sel,
   input  logic                   cmd_use_acc,
   output logic [W-1:0]           alu_a,
   output logic [W-1:0]           alu_b,
   output logic [2:0]             alu_sel,
   input  logic [W-1:0]           alu_out,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [W-1:0]           res_data,
   output logic [2:0]             res_sel,
   output logic [$clog2(DEPTH):0] count
);

   alu_issue_state_t state_q, state_d;
   alu_cmd_t         cmd_in;
   alu_cmd_t         head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic [W-1:0]     issue_a;

   logic [W-1:0]     alu_a_q, alu_a_d;
   logic [W-1:0]     alu_b_q, alu_b_d;
   alu_sel_t         alu_sel_q, alu_sel_d;
   logic [W-1:0]     res_data_q, res_data_d;
   alu_sel_t         res_sel_q, res_sel_d;

   always_comb begin
      cmd_in         = '0;
      cmd_in.a       = cmd_a;
      cmd_in.b       = cmd_b;
      cmd_in.sel     = cmd_sel;
      cmd_in.use_acc = cmd_use_acc;
   end

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cmd_valid && cmd_ready),
      .wr_data (cmd_in),
      .pop     (pop),
      .rd_data (head),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign cmd_ready = !fifo_full;

`ifdef ALU_ISSUE_ACC_EN
   logic [W-1:0] acc_q, acc_d;

   assign issue_a = head.use_acc ? acc_q : head.a;
   assign acc_d   = (state_q == ST_EXEC) ? alu_out : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end
`else
   logic unused_use_acc;

   assign issue_a        = head.a;
   assign unused_use_acc = head.use_acc;
`endif

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      res_data_d = res_data_q;
      res_sel_d  = res_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_data_d = alu_out;
            res_sel_d  = alu_sel_q;
            state_d    = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         alu_a_d   = issue_a;
         alu_b_d   = head.b;
         alu_sel_d = head.sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         res_data_q <= '0;
         res_sel_q  <= '0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         res_data_q <= res_data_d;
         res_sel_q  <= res_sel_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign res_data  = res_data_q;
   assign res_sel   = res_sel_q;
   assign res_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with an adder ALU stub and an in-order result scoreboard.
module tb_alu_issue_stage;

   localparam int DEPTH = 4;
   localparam int W     = 32;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [W-1:0]           cmd_a;
   logic [W-1:0]           cmd_b;
   logic [2:0]             cmd_sel;
   logic                   cmd_use_acc;
   logic [W-1:0]           alu_a;
   logic [W-1:0]           alu_b;
   logic [2:0]             alu_sel;
   logic [W-1:0]           alu_out;
   logic                   res_valid;
   logic                   res_ready;
   logic [W-1:0]           res_data;
   logic [2:0]             res_sel;
   logic [$clog2(DEPTH):0] count;

   typedef struct {
      logic [W-1:0] data;
      logic [2:0]   sel;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] last_res;
   int           total = 0;
   int           bad   = 0;
   int           n_res = 0;
   int           n_mark;

   always #5 clk = ~clk;

   assign alu_out = alu_a + alu_b;

   alu_issue_stage #(.DEPTH(DEPTH), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_sel     (cmd_sel),
      .cmd_use_acc (cmd_use_acc),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_sel     (res_sel),
      .count       (count)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: results come out in push order; with chaining, A is the previous result.
   task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] sel, input logic use_acc);
      exp_t e;
      logic [W-1:0] op_a;
      op_a = a;
`ifdef ALU_ISSUE_ACC_EN
      if (use_acc) op_a = last_res;
`endif
      e.data   = op_a + b;
      e.sel    = sel;
      last_res = e.data;
      exp_q.push_back(e);
   endtask

   // One clock: observe handshakes just before the edge, then land on the next negedge.
   task automatic cyc();
      bit           push, take, hold;
      logic [W-1:0] hd;
      logic [2:0]   hs;
      exp_t         e;
      #1;
      push = cmd_valid && cmd_ready;
      take = res_valid && res_ready;
      hold = res_valid && !res_ready;
      hd   = res_data;
      hs   = res_sel;
      if (take) begin
         chk("result_expected", W'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_sel", W'(res_sel), W'(e.sel));
         end
         n_res++;
      end
      if (push) model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         chk("hold_valid", W'(res_valid), 1);
         chk("hold_data", res_data, hd);
         chk("hold_sel", W'(res_sel), W'(hs));
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic ua);
      cmd_valid   = v;
      cmd_a       = a;
      cmd_b       = b;
      cmd_sel     = sel;
      cmd_use_acc = ua;
   endtask

   task automatic drain(input int budget);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
      chk("drain_left", W'(exp_q.size()), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, W'(cmd_ready), 1);
      chk({tag, "_count"}, W'(count), 0);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_sel"}, W'(alu_sel), 0);
      chk({tag, "_res_valid"}, W'(res_valid), 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_sel"}, W'(res_sel), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      res_ready = 1'b0;
      last_res  = '0;
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Single command latency
      res_ready = 1'b1;
      drive(1'b1, 32'h8, 32'h1, 3'b010, 1'b0);
      cyc();
      drive(1'b0, '0, '0, '0, 1'b0);
      chk("single_count_k", W'(count), 1);
      cyc();
      chk("single_alu_a", alu_a, 32'h8);
      chk("single_alu_b", alu_b, 32'h1);
      chk("single_alu_sel", W'(alu_sel), 3'b010);
      chk("single_valid_k1", W'(res_valid), 0);
      cyc();
      chk("single_valid_k2", W'(res_valid), 1);
      chk("single_data", res_data, 32'h9);
      chk("single_sel", W'(res_sel), 3'b010);
      drain(20);

      // Fill: five pushes with consumer stalled, sixth refused
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, W'(32'h100 + i), W'(i * 3), 3'(i), 1'b0);
         cyc();
      end
      chk("fill_count", W'(count), DEPTH);
      chk("fill_ready", W'(cmd_ready), 0);
      drive(1'b1, 32'hDEAD, 32'hBEEF, 3'b111, 1'b0);
      cyc();
      chk("sixth_count", W'(count), DEPTH);
      chk("sixth_ready", W'(cmd_ready), 0);
      chk("fill_pending", W'(exp_q.size()), 5);
      n_mark = n_res;
      drain(40);
      chk("fill_drained", W'(n_res - n_mark), 5);

      // res_ready toggling over three commands
      n_mark = n_res;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'b0);
         res_ready = i[0];
         cyc();
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         res_ready = i[0];
         cyc();
      end
      chk("toggle_delivered", W'(n_res - n_mark), 3);
      chk("toggle_left", W'(exp_q.size()), 0);

      // Accumulator chaining pair (without the feature, A comes from the command)
      res_ready = 1'b1;
      drive(1'b1, 32'h10, 32'h5, 3'b001, 1'b0);
      cyc();
      drive(1'b1, 32'hFFFF, 32'h3, 3'b001, 1'b1);
      cyc();
`ifdef ALU_ISSUE_ACC_EN
      chk("acc_model_last", exp_q[exp_q.size()-1].data, 32'h18);
`else
      chk("noacc_model_last", exp_q[exp_q.size()-1].data, 32'h10002);
`endif
      drain(20);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         res_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      drain(60);

      // Reset while holding a result with two commands buffered
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'(32'h40 + i), W'(32'h2), 3'(i + 1), 1'b0);
         cyc();
      end
      cmd_valid = 1'b0;
      chk("pre_rst_valid", W'(res_valid), 1);
      chk("pre_rst_count", W'(count), 2);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      exp_q.delete();
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_valid", W'(res_valid), 0);
      chk("post_rst_count", W'(count), 0);
      res_ready = 1'b1;
      drive(1'b1, 32'h77, 32'h11, 3'b101, 1'b0);
      cyc();
      n_mark = n_res;
      drain(20);
      chk("post_rst_result", W'(n_res - n_mark), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
